tanh_layer_scheduler: RTL
=========================

// Module: tanh_layer_scheduler
// PURPOSE
//  Sequences one shared Tanhx unit (LANES lanes wide) over a full layer of
//  LANES*NUM_CHUNKS neuron outputs. Accepts a layer vector via valid/ready, feeds
//  it to Tanhx one LANES-wide chunk at a time (start pulse, wait Finished, capture),
//  and presents the reassembled activated layer via valid/ready to the next layer.
// PARAMETERS
//  DATA_WIDTH  32  width of one IEEE-754 single neuron value
//  LANES       8   neurons per Tanhx pass (= Tanhx No_of_Neurons)
//  NUM_CHUNKS  4   passes per layer; layer width L = DATA_WIDTH*LANES*NUM_CHUNKS
//  TIMEOUT     64  max WAIT cycles per chunk before abort (>=2)
// PORTS
//  clk            in   1               system clock, rising edge
//  reset          in   1               asynchronous, active-low reset
//  in_valid       in   1               layer vector offered
//  in_ready       out  1               scheduler can accept a layer
//  in_data        in   L               layer; chunk k = bits [(k+1)*DATA_WIDTH*LANES-1 : k*DATA_WIDTH*LANES]
//  tanh_start     out  1               to Tanhx reset pin: 1-cycle start/clear pulse
//  tanh_x         out  DATA_WIDTH*LANES  chunk operand to Tanhx x
//  tanh_finished  in   1               Tanhx Finished
//  tanh_result    in   DATA_WIDTH*LANES  Tanhx activatedNeurons
//  out_valid      out  1               activated layer available
//  out_ready      in   1               downstream accepts layer
//  out_data       out  L               activated layer, same chunk placement as in_data
//  busy           out  1               high in any state except IDLE
//  timeout_err    out  1               sticky: a chunk exceeded TIMEOUT
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, chunk=0, wait_cnt=0, in_ready=1, out_valid=0,
//   tanh_start=0, tanh_x=0, out_data=0, busy=0, timeout_err=0. Reset mid-run discards all.
//  FSM: IDLE -> START -> WAIT -> (CAPTURE -> START | CAPTURE -> DONE) -> IDLE.
//  IDLE: in_ready=1. in_valid&in_ready: register in_data, chunk=0, clear timeout_err, -> START.
//  START: tanh_start=1 for exactly this cycle; tanh_x=chunk[chunk]; wait_cnt=0; -> WAIT.
//  WAIT: tanh_x held stable; tanh_start=0; wait_cnt++. tanh_finished ignored when
//   wait_cnt==0 (stale Finished guard). tanh_finished=1 with wait_cnt>=1 -> CAPTURE.
//   wait_cnt reaching TIMEOUT with no Finished: set timeout_err, discard layer, -> IDLE
//   (out_valid never raised for that layer).
//  CAPTURE: tanh_result written into out_data chunk slot [chunk]. chunk==NUM_CHUNKS-1
//   -> DONE, else chunk++ -> START. Finished and timeout in same cycle: Finished wins.
//  DONE: out_valid=1, out_data stable until out_valid&out_ready; then -> IDLE.
//   in_ready=0 in START/WAIT/CAPTURE/DONE (no overlap of layers).
//  Latency per layer (Tanhx latency T cycles after start): NUM_CHUNKS*(T+2)+1 cycles
//   from acceptance to out_valid; 1-cycle bubble IDLE after each handoff.
//  Values pass through unmodified; no arithmetic on data; chunk counter is
//   clog2(NUM_CHUNKS) bits, wait_cnt clog2(TIMEOUT+1) bits, neither wraps.
//  timeout_err clears only on reset or next accepted layer.
// TESTING
//  Stub Tanhx = 3-cycle latency, result = x XOR 0x80000000 per lane, Finished held 1
//  until next start pulse.
//  1 Layer all lanes 0x3F000000 (0.5), out_ready=1 -> out_data all 0xBF000000,
//    4 tanh_start pulses, out_valid at cycle 4*(3+2)+1=21 after accept.
//  2 Distinct lane values 0x00000001..0x00000020 -> each lane sign-flipped, chunk
//    order preserved (lane 0 in LSBs).
//  3 out_ready=0 for 10 cycles in DONE -> out_data/out_valid stable, in_ready=0;
//    raise out_ready -> one transfer, in_ready=1 next cycle.
//  4 Stub never asserts Finished -> timeout_err=1 after 64 WAIT cycles, out_valid stays 0,
//    next layer accepted and completes, timeout_err cleared on accept.
//  5 Assert reset low during WAIT of chunk 2 -> all outputs at reset values immediately;
//    following layer processes from chunk 0 correctly.
//  6 Real Tanhx integration: lanes 0.5,-0.5,2,-2 -> 0.4621,-0.4621,0.9640,-0.9640 (+-1e-3).

Source files
------------

// File: rtl/tanh_layer_scheduler.sv
// Time-multiplexes one LANES-wide Tanhx unit over a layer of LANES*NUM_CHUNKS
// neurons. A layer is taken in over valid/ready and sent to Tanhx one chunk at a
// time. The activated layer is rebuilt chunk by chunk and offered downstream
// over valid/ready.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | ready for a new layer; in_ready_o high
// S_START   | one-cycle start pulse to Tanhx, operand chunk presented
// S_WAIT    | operand held, counting cycles until Finished or timeout
// S_CAPTURE | Tanhx result written into its chunk slot of the output layer
// S_DONE    | activated layer offered downstream until accepted
module tanh_layer_scheduler #(
   parameter  int DATA_WIDTH = 32,
   parameter  int LANES      = 8,
   parameter  int NUM_CHUNKS = 4,
   parameter  int TIMEOUT    = 64,
   localparam int CHW        = DATA_WIDTH * LANES,
   localparam int L          = CHW * NUM_CHUNKS
) (
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [L-1:0]   in_data_i,
   output logic           tanh_start_o,
   output logic [CHW-1:0] tanh_x_o,
   input  logic           tanh_finished_i,
   input  logic [CHW-1:0] tanh_result_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [L-1:0]   out_data_o,
   output logic           busy_o,
   output logic           timeout_err_o
);

   localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_WAIT    = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  chunk_q, chunk_d;
   logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
   logic [L-1:0]   layer_q, layer_d;
   logic [CHW-1:0] tanh_x_q, tanh_x_d;
   logic [L-1:0]   out_data_q, out_data_d;
   logic           err_q, err_d;
   logic [CW-1:0]  chunk_nxt;

   assign chunk_nxt = chunk_q + CW'(1);

   // State register.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: captured layer, operand, rebuilt output, counters.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         chunk_q    <= '0;
         wait_cnt_q <= '0;
         layer_q    <= '0;
         tanh_x_q   <= '0;
         out_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         chunk_q    <= chunk_d;
         wait_cnt_q <= wait_cnt_d;
         layer_q    <= layer_d;
         tanh_x_q   <= tanh_x_d;
         out_data_q <= out_data_d;
         err_q      <= err_d;
      end
   end

   // Next-state and datapath update. The operand is loaded on entry to START
   // so it is already valid during the start pulse.
   always_comb begin
      state_d    = state_q;
      chunk_d    = chunk_q;
      wait_cnt_d = wait_cnt_q;
      layer_d    = layer_q;
      tanh_x_d   = tanh_x_q;
      out_data_d = out_data_q;
      err_d      = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               layer_d  = in_data_i;
               tanh_x_d = in_data_i[CHW-1:0];
               chunk_d  = '0;
               err_d    = 1'b0;
               state_d  = S_START;
            end
         end
         S_START: begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            wait_cnt_d = wait_cnt_q + WW'(1);
            // A Finished seen in the first WAIT cycle is left over from the
            // previous pass. A real Finished takes priority over the timeout.
            if (tanh_finished_i && (wait_cnt_q != '0)) begin
               state_d = S_CAPTURE;
            end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_CAPTURE: begin
            out_data_d[int'(chunk_q)*CHW +: CHW] = tanh_result_i;
            if (chunk_q == CW'(NUM_CHUNKS - 1)) begin
               state_d = S_DONE;
            end else begin
               chunk_d  = chunk_nxt;
               tanh_x_d = layer_q[int'(chunk_nxt)*CHW +: CHW];
               state_d  = S_START;
            end
         end
         S_DONE: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Handshake and status outputs decoded from the state.
   always_comb begin
      in_ready_o   = 1'b0;
      tanh_start_o = 1'b0;
      out_valid_o  = 1'b0;
      busy_o       = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            in_ready_o = 1'b1;
            busy_o     = 1'b0;
         end
         S_START:   tanh_start_o = 1'b1;
         S_DONE:    out_valid_o  = 1'b1;
         default:   ;
      endcase
   end

   assign tanh_x_o      = tanh_x_q;
   assign out_data_o    = out_data_q;
   assign timeout_err_o = err_q;

endmodule
